// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared defaults and FSM state type for the Sobel 3x3 window generator
package sobel_pkg;

    localparam int PIX_W_DEF = 16;
    localparam int IMG_W_DEF = 768;
    localparam int IMG_H_DEF = 768;

    // IDLE   : waiting for the first pixel of a frame
    // PRIME  : filling the two line buffers (rows 0 and 1)
    // STREAM : full neighbourhoods available from row 2 onward
    // DONE   : one-cycle frame-complete state, input back-pressured
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } sobel_state_t;

endpackage

// File: rtl/sobel_line_buf.sv
// rtl/sobel_line_buf.sv - single-line pixel store, read-before-write at one address
//
// Ports:
//   clk      : clock, writes on rising edge
//   we       : write enable
//   addr     : shared read/write address (column)
//   wr_data  : data written at addr when we is high
//   rd_data  : contents of addr before this cycle's write lands
//
// The memory is not reset; the window generator never consumes a location
// before the current frame has written it.
module sobel_line_buf #(
    parameter int DEPTH = 768,
    parameter int WIDTH = 16,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    // Read returns the old word; the write at the same address becomes visible
    // from the next cycle, which lets the caller cascade old data onward.
    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/sobel_window_gen.sv
// rtl/sobel_window_gen.sv - raster-stream to 3x3 neighbourhood generator for a Sobel stage
//
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   pix_valid, pix_in   : raster-order pixel input
//   pix_ready           : input accepted when pix_valid && pix_ready (low only in DONE)
//   px11..px13          : window top row (oldest line), left to right
//   px21..px23          : window middle row
//   px31..px33          : window bottom row (current line), px33 newest
//   start               : one-cycle pulse, window registers hold a complete neighbourhood
//   frame_done          : one-cycle pulse after the last pixel of a frame was accepted
//   eol                 : (only with SOBEL_WIN_EOL_EN) high with start when px33 is the last column
//
// Optional feature macro: SOBEL_WIN_EOL_EN
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int PIX_W = PIX_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_in,
    output logic             pix_ready,
    output logic [PIX_W-1:0] px11,
    output logic [PIX_W-1:0] px12,
    output logic [PIX_W-1:0] px13,
    output logic [PIX_W-1:0] px21,
    output logic [PIX_W-1:0] px22,
    output logic [PIX_W-1:0] px23,
    output logic [PIX_W-1:0] px31,
    output logic [PIX_W-1:0] px32,
    output logic [PIX_W-1:0] px33,
    output logic             start,
`ifdef SOBEL_WIN_EOL_EN
    output logic             eol,
`endif
    output logic             frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    sobel_state_t state, state_nxt;

    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic             accept;
    logic             last_pix;
    logic             win_hit;
    logic [PIX_W-1:0] lb0_rd;
    logic [PIX_W-1:0] lb1_rd;

    assign accept   = pix_valid && pix_ready;
    assign last_pix = (row == ROW_LAST) && (col == COL_LAST);
    // Columns 0/1 of every row and rows 0/1 would produce windows that wrap
    // across a line edge or reach above the frame, so they never start.
    assign win_hit  = (row >= ROW_TWO) && (col >= COL_TWO);

    // FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pix_ready  = 1'b1;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = PRIME;
                end
            end
            PRIME: begin
                if (accept && (row == ROW_TWO) && (col == '0)) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (accept && last_pix) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                pix_ready  = 1'b0;
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Raster position of the pixel currently offered; wraps to 0/0 on the
    // last pixel so the counters are already clear when DONE is entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // LB0 keeps the previous line; LB1 receives what LB0 held at the same
    // column, so it keeps the line before that.
    sobel_line_buf #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W),
        .AW    (CW)
    ) u_lb0 (
        .clk     (clk),
        .we      (accept),
        .addr    (col),
        .wr_data (pix_in),
        .rd_data (lb0_rd)
    );

    sobel_line_buf #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W),
        .AW    (CW)
    ) u_lb1 (
        .clk     (clk),
        .we      (accept),
        .addr    (col),
        .wr_data (lb0_rd),
        .rd_data (lb1_rd)
    );

    // Window shifts left on every accept; new right column comes from the
    // two line buffers and the incoming pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            px11  <= '0;
            px12  <= '0;
            px13  <= '0;
            px21  <= '0;
            px22  <= '0;
            px23  <= '0;
            px31  <= '0;
            px32  <= '0;
            px33  <= '0;
            start <= 1'b0;
        end else begin
            start <= accept && win_hit;
            if (accept) begin
                px11 <= px12;
                px12 <= px13;
                px13 <= lb1_rd;
                px21 <= px22;
                px22 <= px23;
                px23 <= lb0_rd;
                px31 <= px32;
                px32 <= px33;
                px33 <= pix_in;
            end
        end
    end

`ifdef SOBEL_WIN_EOL_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eol <= 1'b0;
        end else begin
            eol <= accept && win_hit && (col == COL_LAST);
        end
    end
`endif

endmodule

// File: tb/tb_sobel_window_gen.sv
// tb/tb_sobel_window_gen.sv - directed self-checking bench for sobel_window_gen on a 4x4 frame
module tb_sobel_window_gen;

    localparam int IMG_W = 4;
    localparam int IMG_H = 4;
    localparam int PIX_W = 16;

    logic             clk;
    logic             reset;
    logic             pix_valid;
    logic [PIX_W-1:0] pix_in;
    logic             pix_ready;
    logic [PIX_W-1:0] px11, px12, px13;
    logic [PIX_W-1:0] px21, px22, px23;
    logic [PIX_W-1:0] px31, px32, px33;
    logic             start;
    logic             frame_done;
`ifdef SOBEL_WIN_EOL_EN
    logic             eol;
`endif

    int checks;
    int failures;
    int n_starts;

    sobel_window_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .PIX_W (PIX_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_valid  (pix_valid),
        .pix_in     (pix_in),
        .pix_ready  (pix_ready),
        .px11       (px11),
        .px12       (px12),
        .px13       (px13),
        .px21       (px21),
        .px22       (px22),
        .px23       (px23),
        .px31       (px31),
        .px32       (px32),
        .px33       (px33),
        .start      (start),
`ifdef SOBEL_WIN_EOL_EN
        .eol        (eol),
`endif
        .frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_win(input string tag, input int b);
        // b is the top-left pixel value; frame values are base + row*4 + col
        check({tag, ".px11"}, 32'(px11), 32'(b + 0));
        check({tag, ".px12"}, 32'(px12), 32'(b + 1));
        check({tag, ".px13"}, 32'(px13), 32'(b + 2));
        check({tag, ".px21"}, 32'(px21), 32'(b + 4));
        check({tag, ".px22"}, 32'(px22), 32'(b + 5));
        check({tag, ".px23"}, 32'(px23), 32'(b + 6));
        check({tag, ".px31"}, 32'(px31), 32'(b + 8));
        check({tag, ".px32"}, 32'(px32), 32'(b + 9));
        check({tag, ".px33"}, 32'(px33), 32'(b + 10));
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input int v);
        pix_valid = 1'b1;
        pix_in    = PIX_W'(v);
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
    endtask

    function automatic logic exp_start(input int idx);
        return ((idx / IMG_W) >= 2) && ((idx % IMG_W) >= 2);
    endfunction

    function automatic logic exp_eol(input int idx);
        return exp_start(idx) && ((idx % IMG_W) == IMG_W - 1);
    endfunction

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        pix_valid = 1'b0;
        pix_in    = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst.pix_ready", 32'(pix_ready), 32'd1);
        check("rst.start", 32'(start), 32'd0);
        check("rst.frame_done", 32'(frame_done), 32'd0);
        check("rst.px11", 32'(px11), 32'd0);
        check("rst.px33", 32'(px33), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Frame 1: pixels 0..15 back-to-back
        n_starts = 0;
        for (int p = 0; p < 16; p++) begin
            send(p);
            check($sformatf("f1.start.p%0d", p), 32'(start), 32'(exp_start(p)));
`ifdef SOBEL_WIN_EOL_EN
            check($sformatf("f1.eol.p%0d", p), 32'(eol), 32'(exp_eol(p)));
`endif
            if (start) n_starts++;
            if (p == 10) check_win("f1.win10", 0);
            if (p == 11) check_win("f1.win11", 1);
            if (p == 14) check_win("f1.win14", 4);
            if (p == 15) begin
                check_win("f1.win15", 5);
                check("f1.frame_done", 32'(frame_done), 32'd1);
                check("f1.ready_done", 32'(pix_ready), 32'd0);
            end else begin
                check($sformatf("f1.no_done.p%0d", p), 32'(frame_done), 32'd0);
            end
        end
        check("f1.n_starts", 32'(n_starts), 32'd4);
        @(posedge clk);
        #1;
        check("f1.idle.frame_done", 32'(frame_done), 32'd0);
        check("f1.idle.pix_ready", 32'(pix_ready), 32'd1);
        check("f1.idle.start", 32'(start), 32'd0);

        // Frame 2: 3-cycle gap between pixels 9 and 10
        for (int p = 0; p < 10; p++) begin
            send(p);
        end
        for (int g = 0; g < 3; g++) begin
            @(posedge clk);
            #1;
            check($sformatf("f2.gap%0d.start", g), 32'(start), 32'd0);
            check($sformatf("f2.gap%0d.px33", g), 32'(px33), 32'd9);
            check($sformatf("f2.gap%0d.px32", g), 32'(px32), 32'd8);
            check($sformatf("f2.gap%0d.px23", g), 32'(px23), 32'd5);
        end
        send(10);
        check("f2.start10", 32'(start), 32'd1);
        check_win("f2.win10", 0);
        for (int p = 11; p < 16; p++) begin
            send(p);
        end
        check("f2.frame_done", 32'(frame_done), 32'd1);
        @(posedge clk);
        #1;

        // Frame 3: abandoned after pixel 7 by reset, then frame 100..115
        for (int p = 0; p < 8; p++) begin
            send(p);
        end
        reset = 1'b1;
        #2;
        check("f3.rst.px33", 32'(px33), 32'd0);
        check("f3.rst.px23", 32'(px23), 32'd0);
        check("f3.rst.start", 32'(start), 32'd0);
        check("f3.rst.pix_ready", 32'(pix_ready), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_starts = 0;
        for (int p = 0; p < 16; p++) begin
            send(100 + p);
            check($sformatf("f4.start.p%0d", p), 32'(start), 32'(exp_start(p)));
            if (start) n_starts++;
            if (p == 10) check_win("f4.win10", 100);
            if (p == 15) begin
                check("f4.frame_done", 32'(frame_done), 32'd1);
                check("f4.ready_done", 32'(pix_ready), 32'd0);
            end
        end
        check("f4.n_starts", 32'(n_starts), 32'd4);
        @(posedge clk);
        #1;
        check("f4.idle.frame_done", 32'(frame_done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
